rv_fetch_seq: RTL and testbench

Instruction fetch sequencer for the uRV pipeline. It owns the program counter, issues read requests to the instruction memory and presents each fetched word, with its PC, to the predecode stage on a valid/stall interface. A one-entry skid buffer preserves full throughput under downstream stalls. Taken branches and jumps from the execute stage redirect fetch and kill all younger in-flight words.

---
 rtl/rv_fetch_seq.sv | 172 +++++++++++++++++
 tb/tb_rv_fetch_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_seq.sv
// rv_fetch_seq: instruction fetch sequencer for the uRV pipeline.
// Owns the PC, issues single-cycle-latency reads to the instruction memory,
// and hands fetched words (with PC) to predecode over a valid/stall
// interface, using a one-entry skid buffer for full throughput under stalls.
// Optional feature macro: RV_FETCH_ALIGN_CHECK_EN (misaligned redirect
// targets deliver a flagged NOP as the first word).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | held in reset / first cycle after release, no fetch
// ST_RUN   | normal fetch, responses land in output or skid register
// ST_FLUSH | one cycle after a redirect that had a request outstanding;
//          | im_data_i is stale and discarded

module rv_fetch_seq #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_pc_bra_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o,
  output logic        f_misaligned_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_nxt;

  logic [31:0] pc_q;
  logic [31:0] out_ir_q, out_pc_q;
  logic        out_v_q, out_mis_q;
  logic [31:0] skid_ir_q, skid_pc_q;
  logic        skid_v_q, skid_mis_q;
  logic        inflight_q, inflight_mis_q;
  logic [31:0] inflight_pc_q;
  logic        mis_pend_q;

  logic        fetching;
  logic        out_free;
  logic        land;
  logic        skid_nv;
  logic        issue;
  logic [31:0] resp_ir;
  logic [31:0] tgt;
  logic        tgt_mis;

  assign tgt = {x_pc_bra_i[31:2], 2'b00};

`ifdef RV_FETCH_ALIGN_CHECK_EN
  assign tgt_mis = |x_pc_bra_i[1:0];
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^x_pc_bra_i[1:0];
  assign tgt_mis        = 1'b0;
`endif

  // Datapath steering: where a response lands and whether a new read may go out
  always_comb begin
    fetching = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    out_free = !out_v_q || !f_stall_i;
    // In FLUSH the returning data belongs to a killed request
    land     = inflight_q && (state_q == ST_RUN) && !x_bra_i;
    resp_ir  = inflight_mis_q ? NOP : im_data_i;
    // Occupancy the skid will have after this edge. Issue is held off whenever
    // it would be occupied, so the next response always has somewhere to go.
    if (skid_v_q) skid_nv = out_free ? land : 1'b1;
    else          skid_nv = land && !out_free;
    issue    = fetching && rst_n_i && !x_bra_i && !skid_nv;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_RESET;
    else          state_q <= state_nxt;
  end

  // FSM next-state logic; a redirect with a request outstanding passes through FLUSH
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RESET: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = (x_bra_i && inflight_q) ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // FSM outputs: memory request port
  always_comb begin
    im_rd_o   = issue;
    im_addr_o = issue ? pc_q : 32'h0;
  end

  // PC, in-flight tracking, output and skid registers; redirect beats everything
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q           <= BOOT_ADDR;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= 32'h0;
      inflight_mis_q <= 1'b0;
      mis_pend_q     <= 1'b0;
      out_ir_q       <= 32'h0;
      out_pc_q       <= 32'h0;
      out_v_q        <= 1'b0;
      out_mis_q      <= 1'b0;
      skid_ir_q      <= 32'h0;
      skid_pc_q      <= 32'h0;
      skid_v_q       <= 1'b0;
      skid_mis_q     <= 1'b0;
    end else if (x_bra_i) begin
      pc_q       <= tgt;
      mis_pend_q <= tgt_mis;
      inflight_q <= 1'b0;
      out_v_q    <= 1'b0;
      out_mis_q  <= 1'b0;
      skid_v_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q           <= pc_q + 32'd4;
        inflight_pc_q  <= pc_q;
        inflight_mis_q <= mis_pend_q;
        mis_pend_q     <= 1'b0;
      end

      if (out_free) begin
        if (skid_v_q) begin
          out_ir_q  <= skid_ir_q;
          out_pc_q  <= skid_pc_q;
          out_mis_q <= skid_mis_q;
          out_v_q   <= 1'b1;
        end else if (land) begin
          out_ir_q  <= resp_ir;
          out_pc_q  <= inflight_pc_q;
          out_mis_q <= inflight_mis_q;
          out_v_q   <= 1'b1;
        end else begin
          out_v_q   <= 1'b0;
          out_mis_q <= 1'b0;
        end
      end

      if ((skid_v_q && out_free) || (!skid_v_q && !out_free)) begin
        skid_v_q <= land;
        if (land) begin
          skid_ir_q  <= resp_ir;
          skid_pc_q  <= inflight_pc_q;
          skid_mis_q <= inflight_mis_q;
        end
      end
    end
  end

  assign f_ir_o         = out_ir_q;
  assign f_pc_o         = out_pc_q;
  assign f_valid_o      = out_v_q;
  assign f_misaligned_o = out_mis_q;

endmodule

// File: tb/tb_rv_fetch_seq.sv
// Testbench for rv_fetch_seq: directed stimulus with literal expectations,
// plus a stream-level model (next expected PC / next expected issue address /
// outstanding word count) checked on every cycle.
module tb_rv_fetch_seq;

  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;
`ifdef RV_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        f_stall_i;
  logic        x_bra_i;
  logic [31:0] x_pc_bra_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;
  logic        f_misaligned_o;

  int n_cmp = 0;
  int n_err = 0;

  rv_fetch_seq #(.BOOT_ADDR(BOOT)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .im_addr_o     (im_addr_o),
    .im_rd_o       (im_rd_o),
    .im_data_i     (im_data_i),
    .f_stall_i     (f_stall_i),
    .x_bra_i       (x_bra_i),
    .x_pc_bra_i    (x_pc_bra_i),
    .f_ir_o        (f_ir_o),
    .f_pc_o        (f_pc_o),
    .f_valid_o     (f_valid_o),
    .f_misaligned_o(f_misaligned_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, garbage when nothing requested
  logic        mem_rd_q = 1'b0;
  logic [31:0] mem_addr_q = 32'h0;
  always @(posedge clk) begin
    mem_rd_q   <= im_rd_o;
    mem_addr_q <= im_addr_o;
  end
  assign im_data_i = mem_rd_q ? (mem_addr_q ^ KEY) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream-level model, checked every cycle away from the clock edge
  logic [31:0] exp_pc, exp_issue;
  bit          exp_mis;
  int          pipe;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n_i) begin
      exp_pc    = BOOT;
      exp_issue = BOOT;
      exp_mis   = 1'b0;
      pipe      = 0;
    end else begin
      if (f_valid_o) begin
        chk("m_pc", f_pc_o, exp_pc);
        chk("m_ir", f_ir_o, exp_mis ? 32'h13 : (exp_pc ^ KEY));
        chk("m_mis", {31'b0, f_misaligned_o}, {31'b0, exp_mis});
      end
      if (im_rd_o) chk("m_addr", im_addr_o, exp_issue);
      if (x_bra_i) begin
        chk("m_rd_on_bra", {31'b0, im_rd_o}, 32'h0);
        exp_pc    = {x_pc_bra_i[31:2], 2'b00};
        exp_issue = exp_pc;
        exp_mis   = ALIGN_EN && (x_pc_bra_i[1:0] != 2'b00);
        pipe      = 0;
      end else begin
        if (im_rd_o) begin
          exp_issue = exp_issue + 32'd4;
          pipe++;
        end
        if (f_valid_o && !f_stall_i) begin
          exp_pc  = exp_pc + 32'd4;
          exp_mis = 1'b0;
          pipe--;
        end
        chk("m_pipe_le2", {31'b0, pipe > 2}, 32'h0);
      end
    end
  end

  // One cycle: drive inputs just after the falling edge, then let comb settle
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst_n_i    = r;
    f_stall_i  = s;
    x_bra_i    = b;
    x_pc_bra_i = t;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'b0, f_valid_o}, 32'h0);
    chk({tag, "_ir"}, f_ir_o, 32'h0);
    chk({tag, "_pc"}, f_pc_o, 32'h0);
    chk({tag, "_rd"}, {31'b0, im_rd_o}, 32'h0);
    chk({tag, "_addr"}, im_addr_o, 32'h0);
    chk({tag, "_mis"}, {31'b0, f_misaligned_o}, 32'h0);
  endtask

  logic [39:0] stall_pat;

  initial begin
    rst_n_i = 1'b0; f_stall_i = 1'b0; x_bra_i = 1'b0; x_pc_bra_i = 32'h0;
    repeat (3) drive(0, 0, 0, 0);
    chk_reset("rst");

    // Boot: edge E samples reset released
    drive(1, 0, 0, 0);
    chk("boot_rd_E", {31'b0, im_rd_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // E+1
    chk("boot_rd", {31'b0, im_rd_o}, 32'h1);
    chk("boot_addr", im_addr_o, 32'h100);
    chk("boot_v1", {31'b0, f_valid_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // E+2
    chk("boot_v2", {31'b0, f_valid_o}, 32'h0);
    chk("boot_addr2", im_addr_o, 32'h104);
    drive(1, 0, 0, 0);                                   // E+3
    chk("boot_v3", {31'b0, f_valid_o}, 32'h1);
    chk("boot_pc", f_pc_o, 32'h100);
    chk("boot_ir", f_ir_o, 32'hA5A5_0100);
    drive(1, 0, 0, 0);                                   // E+4
    chk("s_pc104", f_pc_o, 32'h104);
    drive(1, 0, 0, 0);                                   // E+5

    // Stall 5 cycles: output frozen, no new requests
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0);                                 // E+6..E+10
      chk("stall_pc", f_pc_o, 32'h10C);
      chk("stall_ir", f_ir_o, 32'hA5A5_010C);
      chk("stall_rd", {31'b0, im_rd_o}, 32'h0);
    end
    drive(1, 0, 0, 0);                                   // E+11
    chk("rel_rd", {31'b0, im_rd_o}, 32'h1);
    chk("rel_addr", im_addr_o, 32'h114);
    drive(1, 0, 0, 0);                                   // E+12
    chk("rel_pc110", f_pc_o, 32'h110);
    chk("rel_v", {31'b0, f_valid_o}, 32'h1);
    drive(1, 0, 0, 0);                                   // E+13
    chk("rel_pc114", f_pc_o, 32'h114);

    // Redirect to 0x200 at cycle n
    drive(1, 0, 1, 32'h200);                             // n
    chk("bra_pc_n", f_pc_o, 32'h118);
    drive(1, 0, 0, 0);                                   // n+1
    chk("bra_v1", {31'b0, f_valid_o}, 32'h0);
    chk("bra_addr", im_addr_o, 32'h200);
    drive(1, 0, 0, 0);                                   // n+2
    chk("bra_v2", {31'b0, f_valid_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // n+3
    chk("bra_v3", {31'b0, f_valid_o}, 32'h1);
    chk("bra_pc", f_pc_o, 32'h200);
    chk("bra_ir", f_ir_o, 32'hA5A5_0200);
    drive(1, 0, 0, 0);                                   // n+4

    // Redirect into FLUSH, then a second redirect during FLUSH
    drive(1, 0, 1, 32'h200);                             // m
    chk("fl_pc_m", f_pc_o, 32'h208);
    drive(1, 0, 1, 32'h300);                             // m+1 (FLUSH)
    chk("fl_rd", {31'b0, im_rd_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // m+2
    chk("fl_addr", im_addr_o, 32'h300);
    chk("fl_v2", {31'b0, f_valid_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // m+3
    chk("fl_v3", {31'b0, f_valid_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // m+4
    chk("fl_pc", f_pc_o, 32'h300);
    drive(1, 0, 0, 0);                                   // m+5

    // Redirect together with stall while the skid is full
    drive(1, 1, 0, 0);                                   // m+6
    drive(1, 1, 0, 0);                                   // m+7
    drive(1, 1, 1, 32'h400);                             // m+8
    chk("bs_pc", f_pc_o, 32'h308);
    drive(1, 0, 0, 0);                                   // m+9
    chk("bs_v", {31'b0, f_valid_o}, 32'h0);
    chk("bs_addr", im_addr_o, 32'h400);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);                                   // m+11
    chk("bs_pc400", f_pc_o, 32'h400);

    // Misaligned redirect target
    drive(1, 0, 1, 32'h202);                             // k
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);                                   // k+3
    chk("mis_pc", f_pc_o, 32'h200);
    chk("mis_ir", f_ir_o, ALIGN_EN ? 32'h13 : 32'hA5A5_0200);
    chk("mis_flag", {31'b0, f_misaligned_o}, {31'b0, ALIGN_EN});
    drive(1, 0, 0, 0);                                   // k+4
    chk("mis_pc2", f_pc_o, 32'h204);
    chk("mis_ir2", f_ir_o, 32'hA5A5_0204);
    chk("mis_flag2", {31'b0, f_misaligned_o}, 32'h0);

    // PC wrap-around at the top of the address space
    drive(1, 0, 1, 32'hFFFF_FFF8);                       // w
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);                                   // w+3
    chk("wr_pc0", f_pc_o, 32'hFFFF_FFF8);
    drive(1, 0, 0, 0);
    chk("wr_pc1", f_pc_o, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0);
    chk("wr_pc2", f_pc_o, 32'h0);
    chk("wr_ir2", f_ir_o, 32'hA5A5_0000);

    // Irregular stall pattern, checked by the stream model
    stall_pat = 40'b0110_0011_1010_0001_1101_0110_0100_1111_0010_1100;
    for (int i = 0; i < 40; i++) drive(1, stall_pat[i], 0, 0);
    drive(1, 0, 1, 32'h1000);
    for (int i = 0; i < 8; i++) drive(1, stall_pat[i], 0, 0);

    // Reset mid-stream: pending response dropped, boot again
    drive(0, 0, 0, 0);
    chk("mrst_rd", {31'b0, im_rd_o}, 32'h0);
    drive(0, 0, 0, 0);
    chk_reset("mrst");
    drive(1, 0, 0, 0);                                   // E'
    drive(1, 0, 0, 0);                                   // E'+1
    chk("rb_addr", im_addr_o, 32'h100);
    drive(1, 0, 0, 0);
    chk("rb_v2", {31'b0, f_valid_o}, 32'h0);
    drive(1, 0, 0, 0);                                   // E'+3
    chk("rb_pc", f_pc_o, 32'h100);
    repeat (4) drive(1, 0, 0, 0);

    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
